// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared encodings and helpers for the master-lane load/store unit
//   op codes (LB..SW), bus size codes, FSM states, address-error bit indices,
//   plus size/store/alignment/lane-replication helper functions.
package mem_lsu_pkg;

   typedef enum logic [2:0] {
      OP_LB  = 3'b000,
      OP_LBU = 3'b001,
      OP_LH  = 3'b010,
      OP_LHU = 3'b011,
      OP_LW  = 3'b100,
      OP_SB  = 3'b101,
      OP_SH  = 3'b110,
      OP_SW  = 3'b111
   } mem_op_e;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DONE,
      S_DISCARD
   } state_e;

   localparam int ERR_ADEL = 0;
   localparam int ERR_ADES = 1;

   function automatic logic [1:0] op_size(input logic [2:0] op);
      return (op == OP_LB || op == OP_LBU || op == OP_SB) ? SZ_BYTE :
             (op == OP_LH || op == OP_LHU || op == OP_SH) ? SZ_HALF : SZ_WORD;
   endfunction

   function automatic logic op_is_store(input logic [2:0] op);
      return op == OP_SB || op == OP_SH || op == OP_SW;
   endfunction

   function automatic logic misaligned(input logic [2:0] op, input logic [1:0] off);
      return (op_size(op) == SZ_HALF && off[0]) || (op_size(op) == SZ_WORD && off != 2'b00);
   endfunction

   // Replicate the store operand across all byte lanes so the bus can pick any lane.
   function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] wdata);
      return op_size(op) == SZ_BYTE ? {4{wdata[7:0]}} :
             op_size(op) == SZ_HALF ? {2{wdata[15:0]}} : wdata;
   endfunction

endpackage

// File: rtl/mem_lsu_ext.sv
// mem_lsu_ext: combinational load extract and sign/zero extension
//   op_i   : load op (LB/LBU/LH/LHU/LW)
//   off_i  : byte offset within the word
//   word_i : raw 32-bit bus word
//   data_o : extended 32-bit load result
module mem_lsu_ext
   import mem_lsu_pkg::*;
(
   input  logic [2:0]  op_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] word_i,
   output logic [31:0] data_o
);

   logic [7:0]  b;
   logic [15:0] h;

   assign b = word_i[8*off_i +: 8];
   assign h = off_i[1] ? word_i[31:16] : word_i[15:0];

   always_comb begin
      data_o = op_i == OP_LB  ? {{24{b[7]}}, b}  :
               op_i == OP_LBU ? {24'd0, b}       :
               op_i == OP_LH  ? {{16{h[15]}}, h} :
               op_i == OP_LHU ? {16'd0, h}       : word_i;
   end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: master-lane MEM-stage load/store unit driving an SRAM-like req/addr_ok/data_ok bus
//   clk, rst (async, active-low)
//   M_mem_en/op/addr/wdata, M_except_pending, M_flush, M_stage_ena : pipeline inputs
//   M_mem_rdata, M_mem_stall, M_addr_err (bit0 AdEL, bit1 AdES), M_badvaddr : pipeline outputs
//   data_req/wr/size/addr/wdata : bus request side; data_addr_ok/data_ok/rdata : bus response side
//   Option MEM_LSU_RDATA_BYPASS_EN: forward extended data_rdata in the data_ok cycle.
module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              M_mem_en,
   input  logic [2:0]        M_mem_op,
   input  logic [ADDR_W-1:0] M_mem_addr,
   input  logic [31:0]       M_mem_wdata,
   input  logic              M_except_pending,
   input  logic              M_flush,
   input  logic              M_stage_ena,
   output logic [31:0]       M_mem_rdata,
   output logic              M_mem_stall,
   output logic [1:0]        M_addr_err,
   output logic [ADDR_W-1:0] M_badvaddr,
   output logic              data_req,
   output logic              data_wr,
   output logic [1:0]        data_size,
   output logic [ADDR_W-1:0] data_addr,
   output logic [31:0]       data_wdata,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   input  logic [31:0]       data_rdata
);

   state_e            state_q, state_d, fin_state;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        op_q, op_sel;
   logic [31:0]       wdata_q, res_q, word_sel, ext_data;
   logic [1:0]        off_sel;
   logic              idle, mis, valid, fin, byp, req, stall;

   assign idle = state_q == S_IDLE;
   assign mis  = misaligned(M_mem_op, M_mem_addr[1:0]);

   assign M_addr_err[ERR_ADEL] = M_mem_en & mis & ~op_is_store(M_mem_op);
   assign M_addr_err[ERR_ADES] = M_mem_en & mis & op_is_store(M_mem_op);
   assign M_badvaddr           = M_mem_addr;

   assign valid = M_mem_en & ~M_except_pending & ~M_flush & ~mis;

   // Completion of a live (not discarded) transaction in this cycle.
   assign fin = (((idle & valid) | (state_q == S_REQ & ~M_flush)) & data_addr_ok & data_data_ok) |
                (state_q == S_WAIT & ~M_flush & data_data_ok);

`ifdef MEM_LSU_RDATA_BYPASS_EN
   assign byp = fin;
`else
   assign byp = 1'b0;
`endif

   // With bypass the pipeline may consume the data immediately and skip DONE.
   assign fin_state = (byp & M_stage_ena) ? S_IDLE : S_DONE;

   always_comb begin
      state_d = state_q;
      req     = 1'b0;
      stall   = 1'b0;
      case (state_q)
         S_IDLE: begin
            req   = valid;
            stall = valid;
            if (valid) state_d = fin ? fin_state : data_addr_ok ? S_WAIT : S_REQ;
         end
         S_REQ: begin
            req   = 1'b1;
            stall = 1'b1;
            if (fin) state_d = fin_state;
            else if (data_addr_ok) state_d = M_flush ? (data_data_ok ? S_IDLE : S_DISCARD) : S_WAIT;
            else if (M_flush) state_d = S_IDLE;
         end
         S_WAIT: begin
            stall = 1'b1;
            if (fin) state_d = fin_state;
            else if (M_flush) state_d = data_data_ok ? S_IDLE : S_DISCARD;
         end
         S_DONE: begin
            if (M_stage_ena | M_flush) state_d = S_IDLE;
         end
         S_DISCARD: begin
            stall = valid;
            if (data_data_ok) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (byp) stall = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         op_q    <= '0;
         wdata_q <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         if (idle & valid) begin
            addr_q  <= M_mem_addr;
            op_q    <= M_mem_op;
            wdata_q <= store_data(M_mem_op, M_mem_wdata);
         end
         if (fin) res_q <= data_rdata;
      end
   end

   // In IDLE the request is built from the live inputs; afterwards from the latched copies.
   assign op_sel   = idle ? M_mem_op : op_q;
   assign off_sel  = idle ? M_mem_addr[1:0] : addr_q[1:0];
   assign word_sel = byp ? data_rdata : res_q;

   mem_lsu_ext u_ext (
      .op_i   (op_sel),
      .off_i  (off_sel),
      .word_i (word_sel),
      .data_o (ext_data)
   );

   // Combinational outputs are forced quiet while reset is asserted.
   assign M_mem_rdata = rst ? ext_data : 32'd0;
   assign M_mem_stall = rst & stall;
   assign data_req    = rst & req;
   assign data_wr     = op_is_store(op_sel);
   assign data_size   = op_size(op_sel);
   assign data_addr   = idle ? M_mem_addr : addr_q;
   assign data_wdata  = idle ? store_data(M_mem_op, M_mem_wdata) : wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed, table-driven self-checking bench for mem_lsu
module tb_mem_lsu;
   import mem_lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        M_mem_en, M_except_pending, M_flush, M_stage_ena;
   logic [2:0]  M_mem_op;
   logic [31:0] M_mem_addr, M_mem_wdata, M_mem_rdata, M_badvaddr;
   logic        M_mem_stall;
   logic [1:0]  M_addr_err;
   logic        data_req, data_wr, data_addr_ok, data_data_ok;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata, data_rdata;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [1:0]  err;
      logic [1:0]  sz;
      logic        wr;
      logic [31:0] exp_wd;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vt[14];

   mem_lsu #(.ADDR_W(32)) dut (
      .clk              (clk),
      .rst              (rst),
      .M_mem_en         (M_mem_en),
      .M_mem_op         (M_mem_op),
      .M_mem_addr       (M_mem_addr),
      .M_mem_wdata      (M_mem_wdata),
      .M_except_pending (M_except_pending),
      .M_flush          (M_flush),
      .M_stage_ena      (M_stage_ena),
      .M_mem_rdata      (M_mem_rdata),
      .M_mem_stall      (M_mem_stall),
      .M_addr_err       (M_addr_err),
      .M_badvaddr       (M_badvaddr),
      .data_req         (data_req),
      .data_wr          (data_wr),
      .data_size        (data_size),
      .data_addr        (data_addr),
      .data_wdata       (data_wdata),
      .data_addr_ok     (data_addr_ok),
      .data_data_ok     (data_data_ok),
      .data_rdata       (data_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      M_mem_en = 0; M_except_pending = 0; M_flush = 0; M_stage_ena = 0;
      data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
   endtask

   // One access: addr_ok in the issue cycle, data_ok one cycle later, DONE consumed next.
   task automatic run_vec(input int i, input vec_t t);
      M_mem_en = 1; M_mem_op = t.op; M_mem_addr = t.addr; M_mem_wdata = t.wdata;
      data_addr_ok = 1; data_data_ok = 0; M_stage_ena = 0;
      @(negedge clk);
      chk($sformatf("v%0d_err", i), 32'(M_addr_err), 32'(t.err));
      if (t.err != 2'b00) begin
         chk($sformatf("v%0d_badvaddr", i), M_badvaddr, t.addr);
         chk($sformatf("v%0d_req_err", i), 32'(data_req), 32'd0);
         chk($sformatf("v%0d_stall_err", i), 32'(M_mem_stall), 32'd0);
         tick();
         idle_inputs();
         return;
      end
      chk($sformatf("v%0d_req", i), 32'(data_req), 32'd1);
      chk($sformatf("v%0d_stall0", i), 32'(M_mem_stall), 32'd1);
      chk($sformatf("v%0d_addr", i), data_addr, t.addr);
      chk($sformatf("v%0d_size", i), 32'(data_size), 32'(t.sz));
      chk($sformatf("v%0d_wr", i), 32'(data_wr), 32'(t.wr));
      if (t.wr) chk($sformatf("v%0d_wdata", i), data_wdata, t.exp_wd);
      tick();
      data_addr_ok = 0; data_data_ok = 1; data_rdata = t.rdata;
      @(negedge clk);
      chk($sformatf("v%0d_req_wait", i), 32'(data_req), 32'd0);
      tick();
      data_data_ok = 0; data_rdata = 0; M_stage_ena = 1;
      @(negedge clk);
      chk($sformatf("v%0d_stall_done", i), 32'(M_mem_stall), 32'd0);
      if (!t.wr) chk($sformatf("v%0d_rdata", i), M_mem_rdata, t.exp_rd);
      tick();
      idle_inputs();
   endtask

   initial begin
      int cnt;
      vt[0]  = '{OP_LB,  32'h1003, 32'h0,        32'h80FF1234, 2'b00, SZ_BYTE, 1'b0, 32'h0,        32'hFFFFFF80};
      vt[1]  = '{OP_LBU, 32'h1003, 32'h0,        32'h80FF1234, 2'b00, SZ_BYTE, 1'b0, 32'h0,        32'h00000080};
      vt[2]  = '{OP_LH,  32'h1002, 32'h0,        32'h80FF1234, 2'b00, SZ_HALF, 1'b0, 32'h0,        32'hFFFF80FF};
      vt[3]  = '{OP_LHU, 32'h1000, 32'h0,        32'h80FF9234, 2'b00, SZ_HALF, 1'b0, 32'h0,        32'h00009234};
      vt[4]  = '{OP_LW,  32'h1004, 32'h0,        32'hDEADBEEF, 2'b00, SZ_WORD, 1'b0, 32'h0,        32'hDEADBEEF};
      vt[5]  = '{OP_LB,  32'h1001, 32'h0,        32'h80FF1234, 2'b00, SZ_BYTE, 1'b0, 32'h0,        32'h00000012};
      vt[6]  = '{OP_LH,  32'h1000, 32'h0,        32'h0000F00F, 2'b00, SZ_HALF, 1'b0, 32'h0,        32'hFFFFF00F};
      vt[7]  = '{OP_SB,  32'h2001, 32'h000000A5, 32'h0,        2'b00, SZ_BYTE, 1'b1, 32'hA5A5A5A5, 32'h0};
      vt[8]  = '{OP_SH,  32'h2002, 32'h0000BEEF, 32'h0,        2'b00, SZ_HALF, 1'b1, 32'hBEEFBEEF, 32'h0};
      vt[9]  = '{OP_SW,  32'h2004, 32'h12345678, 32'h0,        2'b00, SZ_WORD, 1'b1, 32'h12345678, 32'h0};
      vt[10] = '{OP_LW,  32'h3001, 32'h0,        32'h0,        2'b01, SZ_WORD, 1'b0, 32'h0,        32'h0};
      vt[11] = '{OP_SH,  32'h2003, 32'h0,        32'h0,        2'b10, SZ_HALF, 1'b1, 32'h0,        32'h0};
      vt[12] = '{OP_LH,  32'h3001, 32'h0,        32'h0,        2'b01, SZ_HALF, 1'b0, 32'h0,        32'h0};
      vt[13] = '{OP_SW,  32'h2002, 32'h0,        32'h0,        2'b10, SZ_WORD, 1'b1, 32'h0,        32'h0};

      // Reset state, with a valid-looking access present during reset.
      idle_inputs();
      rst = 0; M_mem_en = 1; M_mem_op = OP_LW; M_mem_addr = 32'h100; M_mem_wdata = 0;
      #2;
      chk("rst_req", 32'(data_req), 32'd0);
      chk("rst_stall", 32'(M_mem_stall), 32'd0);
      chk("rst_rdata", M_mem_rdata, 32'd0);
      M_mem_en = 0;
      @(negedge clk);
      rst = 1;
      tick();

      for (int i = 0; i < 14; i++) run_vec(i, vt[i]);

      // LB 0x1003: addr_ok in cycle 0, data_ok in cycle 2; count stalled cycles.
      M_mem_en = 1; M_mem_op = OP_LB; M_mem_addr = 32'h1003; data_rdata = 32'h80FF1234;
      cnt = 0;
      for (int c = 0; c < 8; c++) begin
         data_addr_ok = (c == 0);
         data_data_ok = (c == 2);
         @(negedge clk);
         if (!M_mem_stall) break;
         cnt++;
         tick();
      end
`ifdef MEM_LSU_RDATA_BYPASS_EN
      chk("lb_stall_cycles", 32'(cnt), 32'd2);
`else
      chk("lb_stall_cycles", 32'(cnt), 32'd3);
`endif
      chk("lb_rdata", M_mem_rdata, 32'hFFFFFF80);
      M_stage_ena = 1;
      tick();
      idle_inputs();

      // Flush in WAIT: returned data discarded, new access held until data_ok.
      M_mem_en = 1; M_mem_op = OP_LW; M_mem_addr = 32'h5000; data_addr_ok = 1;
      @(negedge clk);
      chk("fl_req_issue", 32'(data_req), 32'd1);
      tick();
      data_addr_ok = 0; M_flush = 1; M_mem_en = 0;
      tick();
      M_flush = 0; M_mem_en = 1; M_mem_addr = 32'h5004;
      @(negedge clk);
      chk("fl_disc_req0", 32'(data_req), 32'd0);
      chk("fl_disc_stall", 32'(M_mem_stall), 32'd1);
      tick();
      @(negedge clk);
      chk("fl_disc_req1", 32'(data_req), 32'd0);
      tick();
      data_data_ok = 1; data_rdata = 32'hBAD0BAD0;
      @(negedge clk);
      chk("fl_disc_req2", 32'(data_req), 32'd0);
      tick();
      data_data_ok = 0; data_rdata = 0;
      @(negedge clk);
      chk("fl_new_req", 32'(data_req), 32'd1);
      chk("fl_new_addr", data_addr, 32'h5004);
      data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'h11112222;
      tick();
      data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
      @(negedge clk);
      chk("fl_new_stall", 32'(M_mem_stall), 32'd0);
      chk("fl_new_rdata", M_mem_rdata, 32'h11112222);
      M_stage_ena = 1;
      tick();
      idle_inputs();

      // DONE held for 4 cycles with stage_ena=0.
      M_mem_en = 1; M_mem_op = OP_LW; M_mem_addr = 32'h6000;
      data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'hCAFEF00D;
      tick();
      data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("hold%0d_rdata", c), M_mem_rdata, 32'hCAFEF00D);
         chk($sformatf("hold%0d_req", c), 32'(data_req), 32'd0);
         chk($sformatf("hold%0d_stall", c), 32'(M_mem_stall), 32'd0);
         tick();
      end
      M_stage_ena = 1;
      tick();
      M_stage_ena = 0; M_mem_addr = 32'h6010;
      @(negedge clk);
      chk("hold_idle_req", 32'(data_req), 32'd1);
      #1;
      M_mem_en = 0;
      tick();

      // Reset asserted in WAIT.
      M_mem_en = 1; M_mem_op = OP_LW; M_mem_addr = 32'h7000; data_addr_ok = 1;
      tick();
      data_addr_ok = 0;
      @(negedge clk);
      chk("rw_stall_wait", 32'(M_mem_stall), 32'd1);
      #2;
      rst = 0;
      #1;
      chk("rw_req", 32'(data_req), 32'd0);
      chk("rw_stall", 32'(M_mem_stall), 32'd0);
      chk("rw_rdata", M_mem_rdata, 32'd0);
      M_mem_en = 0;
      @(negedge clk);
      rst = 1;
      tick();
      M_mem_en = 1; M_mem_addr = 32'h7004;
      @(negedge clk);
      chk("rw_idle_req", 32'(data_req), 32'd1);
      tick();

      // Flush while in REQ before addr_ok: request dropped the next cycle.
      M_flush = 1;
      @(negedge clk);
      chk("fr_req_hold", 32'(data_req), 32'd1);
      chk("fr_addr", data_addr, 32'h7004);
      tick();
      M_flush = 0; M_mem_en = 0;
      @(negedge clk);
      chk("fr_req_drop", 32'(data_req), 32'd0);
      chk("fr_stall", 32'(M_mem_stall), 32'd0);
      tick();

      // Earlier exception suppresses the access.
      M_mem_en = 1; M_except_pending = 1; M_mem_op = OP_LW; M_mem_addr = 32'h9000;
      @(negedge clk);
      chk("exc_req", 32'(data_req), 32'd0);
      chk("exc_stall", 32'(M_mem_stall), 32'd0);
      tick();
      idle_inputs();

`ifdef MEM_LSU_RDATA_BYPASS_EN
      M_mem_en = 1; M_mem_op = OP_LHU; M_mem_addr = 32'h4002;
      data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'hABCD0000; M_stage_ena = 1;
      @(negedge clk);
      chk("byp_stall", 32'(M_mem_stall), 32'd0);
      chk("byp_rdata", M_mem_rdata, 32'h0000ABCD);
      tick();
      idle_inputs();
      M_mem_en = 1; M_mem_op = OP_LW; M_mem_addr = 32'h4100;
      @(negedge clk);
      chk("byp_idle_req", 32'(data_req), 32'd1);
      #1;
      M_mem_en = 0;
      tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
